// File: rtl/func_unit_ctrl.sv
// Sequencer between decode and the custom-opcode accelerator. It launches the operation, stalls the upstream pipeline, and returns the result as a write-back request.
// Optional BUSY watchdog: define FUNC_UNIT_CTRL_TIMEOUT_EN to enable it.
module func_unit_ctrl #(
  parameter int DATA_W  = 8,
  parameter int RES_W   = 16,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [4:0]        rd_i,
  output logic              acc_start_o,
  output logic [DATA_W-1:0] acc_a_o,
  output logic [DATA_W-1:0] acc_b_o,
  input  logic              acc_done_i,
  input  logic [RES_W-1:0]  acc_result_i,
  output logic              stall_o,
  output logic              wb_valid_o,
  output logic [4:0]        wb_rd_o,
  output logic [31:0]       wb_data_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  op_count_o,
  output logic [1:0]        state_dbg_o
);

  // Handshake: acc_start_o is a one-cycle launch pulse. acc_a_o/acc_b_o are then held
  // until acc_done_i, which is sampled only in BUSY together with acc_result_i.
  // wb_valid_o is a one-cycle request and has no back-pressure.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2,
    ST_WB     = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
  logic [4:0]         rd_q, rd_d;
  logic               acc_start_q, acc_start_d;
  logic               stall_q, stall_d;
  logic               wb_valid_q, wb_valid_d;
  logic [4:0]         wb_rd_q, wb_rd_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   op_count_q, op_count_d;
  logic               timeout_hit;

`ifdef FUNC_UNIT_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1) + 1;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  // The counter sits at zero outside BUSY, so it is cleared on every BUSY entry.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == ST_BUSY) tmo_cnt_d = tmo_cnt_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end

  // This fires on the TIMEOUT-th BUSY cycle. A done in that same cycle wins.
  assign timeout_hit = (state_q == ST_BUSY) && (tmo_cnt_q == TW'(TIMEOUT - 1)) && !acc_done_i;
`else
  // TIMEOUT is always positive, so this is constant 0 and BUSY waits for done indefinitely.
  assign timeout_hit = (TIMEOUT < 0);
`endif

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    rd_d        = rd_q;
    acc_start_d = 1'b0;
    stall_d     = 1'b0;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    err_d       = 1'b0;
    op_count_d  = op_count_q;
    unique case (state_q)
      ST_IDLE, ST_WB: begin
        // The WB cycle accepts a new request directly, so back-to-back ops skip IDLE.
        if (start_i) begin
          a_d         = a_i;
          b_d         = b_i;
          rd_d        = rd_i;
          state_d     = ST_LAUNCH;
          acc_start_d = 1'b1;
          stall_d     = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_BUSY;
        stall_d = 1'b1;
      end
      ST_BUSY: begin
        if (acc_done_i) begin
          state_d    = ST_WB;
          wb_data_d  = 32'(acc_result_i);
          wb_valid_d = (rd_q != 5'd0);
          wb_rd_d    = rd_q;
          op_count_d = op_count_q + CNT_W'(1);
        end else if (timeout_hit) begin
          state_d    = ST_WB;
          wb_data_d  = 32'hFFFF_FFFF;
          wb_valid_d = (rd_q != 5'd0);
          wb_rd_d    = rd_q;
          err_d      = 1'b1;
        end else begin
          stall_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      rd_q        <= '0;
      acc_start_q <= 1'b0;
      stall_q     <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      err_q       <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rd_q        <= rd_d;
      acc_start_q <= acc_start_d;
      stall_q     <= stall_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      err_q       <= err_d;
      op_count_q  <= op_count_d;
    end
  end

  assign acc_start_o = acc_start_q;
  assign acc_a_o     = a_q;
  assign acc_b_o     = b_q;
  assign stall_o     = stall_q;
  assign wb_valid_o  = wb_valid_q;
  assign wb_rd_o     = wb_rd_q;
  assign wb_data_o   = wb_data_q;
  assign err_o       = err_q;
  assign op_count_o  = op_count_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_func_unit_ctrl.sv
// Directed self-checking bench for func_unit_ctrl. It covers reset, a single op, a back-to-back op, rd=0, a mid-op reset and the watchdog.
// The bench builds with or without FUNC_UNIT_CTRL_TIMEOUT_EN.
module tb_func_unit_ctrl;
  localparam int DATA_W = 8;
  localparam int RES_W  = 16;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start_i;
  logic [DATA_W-1:0] a_i, b_i;
  logic [4:0]        rd_i;
  logic              acc_start_o;
  logic [DATA_W-1:0] acc_a_o, acc_b_o;
  logic              acc_done_i;
  logic [RES_W-1:0]  acc_result_i;
  logic              stall_o, wb_valid_o, err_o;
  logic [4:0]        wb_rd_o;
  logic [31:0]       wb_data_o;
  logic [CNT_W-1:0]  op_count_o;
  logic [1:0]        state_dbg_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  func_unit_ctrl #(.DATA_W(DATA_W), .RES_W(RES_W), .TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .a_i(a_i), .b_i(b_i), .rd_i(rd_i),
    .acc_start_o(acc_start_o), .acc_a_o(acc_a_o), .acc_b_o(acc_b_o),
    .acc_done_i(acc_done_i), .acc_result_i(acc_result_i), .stall_o(stall_o),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .err_o(err_o), .op_count_o(op_count_o), .state_dbg_o(state_dbg_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [4:0] rd);
    start_i = 1'b1;
    a_i = a;
    b_i = b;
    rd_i = rd;
  endtask

  task automatic done(input logic [15:0] res);
    acc_done_i = 1'b1;
    acc_result_i = res;
    exp_q.push_back({16'h0000, res});
  endtask

  initial begin
    rst_n = 1'b0;
    start_i = 1'b1;
    a_i = 8'hFF;
    b_i = 8'hFF;
    rd_i = 5'd31;
    acc_done_i = 1'b0;
    acc_result_i = '0;

    // Reset held for 3 cycles while a start request is present.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_state", 32'(state_dbg_o), 32'd0);
      chk("rst_start", 32'(acc_start_o), 32'd0);
      chk("rst_stall", 32'(stall_o), 32'd0);
    end
    chk("rst_outs", {acc_a_o, acc_b_o, 3'b0, wb_rd_o, 7'b0, wb_valid_o}, 32'd0);
    chk("rst_data", wb_data_o, 32'd0);
    chk("rst_cnt", 32'(op_count_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);

    // Single op at cycle T with N=4.
    rst_n = 1'b1;
    issue(8'h12, 8'h34, 5'd5);
    tick();
    start_i = 1'b0;
    chk("t1_start", 32'(acc_start_o), 32'd1);
    chk("t1_stall", 32'(stall_o), 32'd1);
    chk("t1_opa", 32'(acc_a_o), 32'h12);
    chk("t1_opb", 32'(acc_b_o), 32'h34);
    for (int i = 2; i <= 5; i++) begin
      tick();
      if (i == 5) done(16'h03A8);
      chk("busy_start", 32'(acc_start_o), 32'd0);
      chk("busy_stall", 32'(stall_o), 32'd1);
      chk("busy_opa", 32'(acc_a_o), 32'h12);
    end
    tick();
    acc_done_i = 1'b0;
    chk("t6_wbv", 32'(wb_valid_o), 32'd1);
    chk("t6_rd", 32'(wb_rd_o), 32'd5);
    chk("t6_data", wb_data_o, exp_q.pop_front());
    chk("t6_cnt", 32'(op_count_o), 32'd1);
    chk("t6_stall", 32'(stall_o), 32'd0);
    chk("t6_state", 32'(state_dbg_o), 32'd3);

    // Back-to-back: a new request arrives in the WB cycle.
    issue(8'h01, 8'h02, 5'd7);
    tick();
    start_i = 1'b0;
    chk("b2b_state", 32'(state_dbg_o), 32'd1);
    chk("b2b_start", 32'(acc_start_o), 32'd1);
    chk("b2b_opa", 32'(acc_a_o), 32'h01);
    chk("b2b_opb", 32'(acc_b_o), 32'h02);
    chk("b2b_wbv", 32'(wb_valid_o), 32'd0);
    chk("b2b_rdhold", 32'(wb_rd_o), 32'd5);
    tick();
    done(16'h0055);
    tick();
    acc_done_i = 1'b0;
    chk("b2b_wb", 32'(wb_valid_o), 32'd1);
    chk("b2b_rd", 32'(wb_rd_o), 32'd7);
    chk("b2b_data", wb_data_o, exp_q.pop_front());
    chk("b2b_cnt", 32'(op_count_o), 32'd2);

    // rd=0: the op still counts, but no write-back request is raised.
    issue(8'h03, 8'h04, 5'd0);
    tick();
    start_i = 1'b0;
    tick();
    done(16'hBEEF);
    tick();
    acc_done_i = 1'b0;
    chk("rd0_wbv", 32'(wb_valid_o), 32'd0);
    chk("rd0_data", wb_data_o, exp_q.pop_front());
    chk("rd0_cnt", 32'(op_count_o), 32'd3);
    tick();
    chk("idle_state", 32'(state_dbg_o), 32'd0);
    chk("idle_wbv", 32'(wb_valid_o), 32'd0);
    chk("idle_hold", wb_data_o, 32'h0000_BEEF);

    // Reset during BUSY; a late done after release must be ignored.
    issue(8'h09, 8'h0A, 5'd3);
    tick();
    start_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_state", 32'(state_dbg_o), 32'd0);
    chk("mrst_cnt", 32'(op_count_o), 32'd0);
    tick();
    acc_done_i = 1'b1;
    acc_result_i = 16'h1234;
    tick();
    acc_done_i = 1'b0;
    chk("mrst_wbv", 32'(wb_valid_o), 32'd0);
    chk("mrst_stall", 32'(stall_o), 32'd0);
    chk("mrst_cnt2", 32'(op_count_o), 32'd0);
    chk("mrst_idle", 32'(state_dbg_o), 32'd0);

    // Watchdog: done never arrives.
    issue(8'h05, 8'h06, 5'd4);
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("tmo_busy", 32'(stall_o), 32'd1);
      chk("tmo_noerr", 32'(err_o), 32'd0);
    end
    tick();
`ifdef FUNC_UNIT_CTRL_TIMEOUT_EN
    chk("tmo_err", 32'(err_o), 32'd1);
    chk("tmo_wbv", 32'(wb_valid_o), 32'd1);
    chk("tmo_data", wb_data_o, 32'hFFFF_FFFF);
    chk("tmo_cnt", 32'(op_count_o), 32'd0);
    tick();
    chk("tmo_pulse", 32'(err_o), 32'd0);
    // A done on the timeout cycle wins and completes normally.
    issue(8'h07, 8'h08, 5'd2);
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 7) done(16'h0042);
    end
    tick();
    acc_done_i = 1'b0;
    chk("race_err", 32'(err_o), 32'd0);
    chk("race_data", wb_data_o, exp_q.pop_front());
    chk("race_cnt", 32'(op_count_o), 32'd1);
`else
    for (int i = 0; i < 12; i++) tick();
    chk("hang_stall", 32'(stall_o), 32'd1);
    chk("hang_err", 32'(err_o), 32'd0);
    chk("hang_state", 32'(state_dbg_o), 32'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/func_unit_ctrl.md
Name: func_unit_ctrl

Overview:
Sequencer between the decode stage and the custom-opcode accelerator (opcode 7'b1111111, 8-bit operands A and B).
- Takes the one-cycle start request plus operands from decode.
- Launches the multi-cycle accelerator with a start/done handshake.
- Freezes the upstream pipeline while the operation is in flight.
- Returns the zero-extended result as a register write-back request.

Parameters:
DATA_W, 8, operand width of A/B.
RES_W, 16, accelerator result width (at most 32).
TIMEOUT, 64, maximum BUSY cycles before forced abort (used only with the optional feature).
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  synchronous active-low reset.
start_i  in  1  custom-op request from decode (start_module).
a_i  in  DATA_W  operand A from decode.
b_i  in  DATA_W  operand B from decode.
rd_i  in  5  destination register of the custom op.
acc_start_o  out  1  one-cycle launch pulse to the accelerator.
acc_a_o  out  DATA_W  latched operand A, stable from launch until done.
acc_b_o  out  DATA_W  latched operand B, stable from launch until done.
acc_done_i  in  1  accelerator completion strobe.
acc_result_i  in  RES_W  accelerator result, valid with acc_done_i.
stall_o  out  1  freeze request to fetch/decode.
wb_valid_o  out  1  one-cycle write-back request.
wb_rd_o  out  5  write-back destination.
wb_data_o  out  32  write-back data.
err_o  out  1  timeout abort pulse.
op_count_o  out  CNT_W  number of completed operations.

Behaviour:
- States: IDLE, LAUNCH, BUSY, WB. All outputs are registered.
- Reset (rst_n=0 at a clock edge):
  - state=IDLE.
  - All outputs 0, including acc_a_o/acc_b_o, wb_rd_o, wb_data_o, op_count_o.
  - Reset takes priority over every other event, including mid-operation. An in-flight result is dropped, and a later acc_done_i in IDLE is ignored.
- IDLE:
  - On start_i=1: latch a_i, b_i, rd_i and go to LAUNCH.
  - Otherwise stay in IDLE.
- LAUNCH (exactly 1 cycle): acc_start_o=1, stall_o=1, then go to BUSY. acc_done_i is not sampled in this cycle.
- BUSY:
  - stall_o=1, acc_start_o=0.
  - On acc_done_i=1: capture {zero-extend, acc_result_i} into wb_data_o and go to WB.
- WB (exactly 1 cycle):
  - wb_valid_o=1 unless the latched rd is 0. With rd=0, wb_valid_o=0 but the op still counts.
  - wb_rd_o holds the latched rd; stall_o=0.
  - op_count_o increments by 1 and wraps from 2^CNT_W-1 to 0.
  - Next state: LAUNCH if start_i=1 (back-to-back; new operands latched), else IDLE.
- Output timing:
  - wb_valid_o and err_o are single-cycle pulses.
  - wb_rd_o and wb_data_o hold their values until the next WB.
- start_i during LAUNCH or BUSY is ignored; decode is frozen, so this is a protocol violation.
- Latency: start_i at cycle T → acc_start_o at T+1 → done at T+1+N (N≥1) → wb_valid_o at T+2+N. stall_o is high during cycles T+1 through T+1+N.
- Operand outputs are held constant from LAUNCH through BUSY.

Optional Feature:
FUNC_UNIT_CTRL_TIMEOUT_EN
- Defined:
  - A BUSY-cycle counter is cleared on entry to BUSY.
  - If the counter reaches TIMEOUT without acc_done_i, go to WB with wb_data_o=32'hFFFF_FFFF and err_o=1 for that WB cycle. op_count_o does not increment on an abort.
  - acc_done_i in the same cycle as the timeout wins: normal completion.
- Undefined: no counter; BUSY waits indefinitely; err_o tied to 0.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start_i=1 → every output is 0 and state is IDLE. Release → first launch occurs one cycle after start_i.
- Single op: start_i pulse, a=8'h12, b=8'h34, rd=5; done after N=4 with result 16'h03A8 → acc_start_o at T+1, stall_o high for T+1..T+5, wb_valid_o at T+6 with wb_rd_o=5, wb_data_o=32'h0000_03A8, op_count_o=1.
- Back-to-back: second start_i in the WB cycle (a=8'h01, b=8'h02, rd=7) → LAUNCH on the next cycle with no IDLE cycle, and acc_a_o=8'h01. After completion, op_count_o=2.
- rd=0: op completes with result 16'hBEEF → wb_valid_o stays 0, wb_data_o=32'h0000_BEEF, op_count_o increments.
- Reset mid-op: rst_n=0 during BUSY, then acc_done_i one cycle after release → no wb_valid_o, stall_o=0, op_count_o=0.
- Timeout (FUNC_UNIT_CTRL_TIMEOUT_EN, TIMEOUT=8): never assert done → after 8 BUSY cycles err_o=1, wb_valid_o=1, wb_data_o=32'hFFFF_FFFF, op_count_o unchanged. Without the macro → stall_o stays high and err_o=0.
